// File: rtl/shift_reg_n.sv
// N-bit shift register: single-step hold/shift/load plus a counted burst shift FSM.
// Optional SHIFT_REG_ROTATE_EN adds rotate_i, recirculating the outgoing bit on shifts.
module shift_reg_n #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [1:0]                   mode_i,
  input  logic [WIDTH-1:0]             d_i,
  input  logic                         sin_r_i,
  input  logic                         sin_l_i,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                         rotate_i,
`endif
  input  logic                         start_i,
  input  logic                         dir_i,
  input  logic [$clog2(WIDTH+1)-1:0]   amount_i,
  output logic [WIDTH-1:0]             q_o,
  output logic                         sout_r_o,
  output logic                         sout_l_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  q_q;
  logic [CW-1:0]     cnt_q;
  logic              dir_q;
  logic              busy_q;
  logic              done_q;

  logic              rot;
  logic              rin_r, rin_l;
  logic [WIDTH-1:0]  shr, shl;
  logic [CW-1:0]     amt_sat;

`ifdef SHIFT_REG_ROTATE_EN
  assign rot = rotate_i;
`else
  assign rot = 1'b0;
`endif

  // With rotate, the bit leaving one end re-enters at the other.
  assign rin_r   = rot ? q_q[0]       : sin_r_i;
  assign rin_l   = rot ? q_q[WIDTH-1] : sin_l_i;
  assign shr     = {rin_r, q_q[WIDTH-1:1]};
  assign shl     = {q_q[WIDTH-2:0], rin_l};
  assign amt_sat = (amount_i > CNT_MAX) ? CNT_MAX : amount_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            // Start wins over en/mode; q is left alone on the accept cycle.
            dir_q <= dir_i;
            cnt_q <= amt_sat;
            if (amt_sat != '0) begin
              state_q <= BURST;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end else if (en_i) begin
            case (mode_i)
              2'b01:   q_q <= shr;
              2'b10:   q_q <= shl;
              2'b11:   q_q <= d_i;
              default: q_q <= q_q;
            endcase
          end
        end
        BURST: begin
          q_q   <= dir_q ? shl : shr;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q_o      = q_q;
  assign sout_r_o = q_q[0];
  assign sout_l_o = q_q[WIDTH-1];
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(busy_q && done_q));
  a_busy_state:     assert property (@(posedge clk_i) disable iff (!rst_ni) busy_q == (state_q == BURST));

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n (WIDTH=8, RESET_VALUE=0): vector table plus burst sequences.
module tb_shift_reg_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sin_r, sin_l, start, dir;
  logic [1:0] mode;
  logic [7:0] d;
  logic [3:0] amount;
  logic [7:0] q;
  logic       sout_r, sout_l, busy, done;
`ifdef SHIFT_REG_ROTATE_EN
  logic       rotate;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_reg_n #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .d_i(d),
    .sin_r_i(sin_r), .sin_l_i(sin_l),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate_i(rotate),
`endif
    .start_i(start), .dir_i(dir), .amount_i(amount),
    .q_o(q), .sout_r_o(sout_r), .sout_l_o(sout_l), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    en = v.en; mode = v.mode; d = v.d; sin_r = v.sr; sin_l = v.sl; start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " q"}, 32'(q), 32'(v.exp_q));
    chk({nm, " sout_r"}, 32'(sout_r), 32'(v.exp_q[0]));
    chk({nm, " sout_l"}, 32'(sout_l), 32'(v.exp_q[7]));
  endtask

  // Issues start, counts busy cycles, leaves time at the done sample when chain=1.
  task automatic burst(input logic dr, input logic [3:0] amt, input logic sr, input logic sl,
                       input logic [7:0] exp_q, input int exp_n, input bit noise, input bit chain,
                       input string nm);
    logic [7:0] q0;
    int nb, k;
    bit early;
    @(negedge clk);
    q0 = q; start = 1'b1; dir = dr; amount = amt; sin_r = sr; sin_l = sl; en = 1'b0; mode = 2'b00;
    @(posedge clk); #1;
    chk({nm, " q held on accept"}, 32'(q), 32'(q0));
    start = 1'b0;
    if (noise) begin start = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h55; end
    nb = 0; k = 0; early = 1'b0;
    while (busy === 1'b1 && k < 40) begin
      nb++;
      if (done !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; en = 1'b0; mode = 2'b00;
    chk({nm, " busy cycles"}, 32'(nb), 32'(exp_n));
    chk({nm, " done pulse"}, 32'(done), 32'd1);
    chk({nm, " no done while busy"}, 32'(early), 32'd0);
    chk({nm, " final q"}, 32'(q), 32'(exp_q));
    if (!chain) begin
      @(posedge clk); #1;
      chk({nm, " done one cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hD2};
    tbl[2] = '{1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{1'b0, 2'b11, 8'h00, 1'b1, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 8'hA5};
    tbl[5] = '{1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 8'h52};
    tbl[6] = '{1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 8'hA4};
    tbl[7] = '{1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81};

    rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; dir = 1'b0; amount = 4'd0;
`ifdef SHIFT_REG_ROTATE_EN
    rotate = 1'b0;
`endif
    #2;
    chk("reset q", 32'(q), 32'h00);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(tbl[i], $sformatf("vec%0d", i));

    burst(1'b1, 4'd3,  1'b0, 1'b0, 8'h08, 3, 1'b0, 1'b0, "left3");
    burst(1'b0, 4'd0,  1'b1, 1'b1, 8'h08, 0, 1'b0, 1'b0, "amt0");
    burst(1'b1, 4'd15, 1'b0, 1'b1, 8'hFF, 8, 1'b0, 1'b0, "amt15");
    burst(1'b0, 4'd4,  1'b0, 1'b0, 8'h0F, 4, 1'b1, 1'b1, "noise");

    // New start accepted in the same cycle done is high.
    start = 1'b1; dir = 1'b0; amount = 4'd2; sin_r = 1'b1;
    @(posedge clk); #1;
    chk("chain busy", 32'(busy), 32'd1);
    chk("chain done", 32'(done), 32'd0);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("chain end busy", 32'(busy), 32'd0);
    chk("chain end done", 32'(done), 32'd1);
    chk("chain q", 32'(q), 32'hC3);

    // Reset in the middle of a burst: immediate clear, no done afterwards.
    @(negedge clk);
    start = 1'b1; dir = 1'b1; amount = 4'd8; sin_l = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midburst reset q", 32'(q), 32'h00);
    chk("midburst reset busy", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset done", 32'(done), 32'd0);
    chk("post reset busy", 32'(busy), 32'd0);
    step('{1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C}, "first load");
    step('{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h9E}, "shr after reset");

`ifdef SHIFT_REG_ROTATE_EN
    step('{1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81}, "rot load");
    rotate = 1'b1;
    burst(1'b0, 4'd1, 1'b0, 1'b0, 8'hC0, 1, 1'b0, 1'b0, "rotate right1");
    step('{1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'h81}, "rotate step left");
    rotate = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
